// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch-stage front end. Holds the program counter, drives the
//                instruction memory read port, and registers the returned
//                instruction toward decode with a valid/ready handshake.
//                Handles redirect/flush and flags misaligned or out-of-range
//                fetch addresses with a sticky fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int            WIDTH        = 32,
   parameter int            ADDRESS_SIZE = 10,
   parameter int            PC_WIDTH     = 32,
   parameter logic [31:0]   RESET_PC     = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDRESS_SIZE-1:0] imem_addr,
   output logic                    imem_read_en,
   input  logic [WIDTH-1:0]        imem_instruction,
   input  logic                    redirect_valid,
   input  logic [PC_WIDTH-1:0]     redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_instruction,
   output logic [PC_WIDTH-1:0]     out_pc,
   output logic                    fault,
   output logic [PC_WIDTH-1:0]     fault_pc
);

   localparam logic [1:0] c_state_boot  = 2'd0;
   localparam logic [1:0] c_state_fetch = 2'd1;
   localparam logic [1:0] c_state_fault = 2'd2;

   localparam logic [PC_WIDTH-1:0] c_pc_step  = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0] c_pc_reset = PC_WIDTH'(RESET_PC);

   logic [1:0]          r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_instruction;
   logic [PC_WIDTH-1:0] r_out_pc;
   logic                r_fault;
   logic [PC_WIDTH-1:0] r_fault_pc;

   logic w_pc_ok;
   logic w_load;

   // PC is fetchable when word aligned and inside the addressable memory range;
   // a load happens only when the output slot is free or being drained.
   always_comb begin
      w_pc_ok = (r_pc[1:0] == 2'b00) &&
                (r_pc[PC_WIDTH-1:ADDRESS_SIZE+2] == '0);
      w_load  = (r_state == c_state_fetch) && w_pc_ok && !redirect_valid &&
                (!r_out_valid || out_ready);
   end

   assign imem_addr       = r_pc[ADDRESS_SIZE+1:2];
   assign imem_read_en    = w_load;
   assign out_valid       = r_out_valid;
   assign out_instruction = r_out_instruction;
   assign out_pc          = r_out_pc;
   assign fault           = r_fault;
   assign fault_pc        = r_fault_pc;

   // State, PC, output register and fault tracking; redirect outranks fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= c_state_boot;
         r_pc              <= c_pc_reset;
         r_out_valid       <= 1'b0;
         r_out_instruction <= '0;
         r_out_pc          <= '0;
         r_fault           <= 1'b0;
         r_fault_pc        <= '0;
      end else if (redirect_valid) begin
         // In BOOT nothing is in flight, so only the restart address matters.
         r_pc    <= redirect_pc;
         r_state <= c_state_fetch;
         if (r_state != c_state_boot) begin
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
         end
      end else begin
         if (w_load) begin
            r_out_instruction <= imem_instruction;
            r_out_pc          <= r_pc;
            r_out_valid       <= 1'b1;
            r_pc              <= r_pc + c_pc_step;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            c_state_boot: begin
               r_state <= c_state_fetch;
            end
            c_state_fetch: begin
               // A pending output still drains through the handshake above.
               if (!w_pc_ok) begin
                  r_state    <= c_state_fault;
                  r_fault    <= 1'b1;
                  r_fault_pc <= r_pc;
               end
            end
            c_state_fault: begin
               r_state <= c_state_fault;
            end
            default: begin
               r_state <= c_state_boot;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
